// File: rtl/sum_arbiter_pkg.sv
// Shared types and defaults for the shared-adder arbiter.
package sum_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StRun    = 2'd2
  } arb_state_e;

  localparam int unsigned DefNClients = 2;
  localparam int unsigned DefWidth    = 16;
  localparam int unsigned CountWidth  = 16;

  // Pointer width that stays >= 1 even for degenerate client counts.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_arbiter_rr_pick.sv
// Combinational round-robin picker: first candidate at or after ptr_i, one-hot result.
module sum_arbiter_rr_pick
  import sum_arbiter_pkg::*;
#(
  parameter int unsigned NClients = DefNClients,
  parameter int unsigned PtrW     = ptr_width(DefNClients)
) (
  input  logic [NClients-1:0] cand_i,
  input  logic [PtrW-1:0]     ptr_i,
  output logic [NClients-1:0] grant_o,
  output logic                valid_o
);

  // Scan from the pointer, wrapping, and keep only the first hit.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx     = '0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < NClients; off++) begin
      idx = PtrW'((32'(ptr_i) + off) % NClients);
      if (!valid_o && cand_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin owner of a single shared adder. One client holds the adder for a whole
// transaction (LAUNCH then RUN while its busy_i is high).
// Optional per-client transaction counters: define SUM_ARB_STATS_EN.
module sum_arbiter
  import sum_arbiter_pkg::*;
#(
  parameter int unsigned N_CLIENTS = DefNClients,
  parameter int unsigned WIDTH     = DefWidth
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CLIENTS-1:0]         req_i,
  output logic [N_CLIENTS-1:0]         start_o,
  input  logic [N_CLIENTS-1:0]         busy_i,
  output logic [N_CLIENTS-1:0]         grant_o,
  input  logic [N_CLIENTS*WIDTH-1:0]   sum_in_a_i,
  input  logic [N_CLIENTS*WIDTH-1:0]   sum_in_b_i,
  output logic [WIDTH-1:0]             sum_out,
  output logic                         busy,
`ifdef SUM_ARB_STATS_EN
  output logic [N_CLIENTS*CountWidth-1:0] txn_count,
`endif
  output logic                         err_o
);

  localparam int unsigned PtrW = ptr_width(N_CLIENTS);

  arb_state_e             state_q, state_d;
  logic [N_CLIENTS-1:0]   pending_q, pending_d;
  logic [N_CLIENTS-1:0]   grant_q, grant_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   first_q, first_d;

  logic [N_CLIENTS-1:0]   pick_grant;
  logic                   pick_valid;
  logic [PtrW-1:0]        g_idx;
  logic                   granted_busy;
  logic                   release_run;
  logic [WIDTH-1:0]       a_sel, b_sel;

  sum_arbiter_rr_pick #(
    .NClients (N_CLIENTS),
    .PtrW     (PtrW)
  ) u_pick (
    .cand_i  (pending_q | req_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  // Encode the one-hot grant and the granted client's busy.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      if (grant_q[i]) g_idx = PtrW'(i);
    end
    granted_busy = |(busy_i & grant_q);
    release_run  = (state_q == StRun) && !granted_busy;
  end

  // State register and transaction bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      first_q   <= first_d;
    end
  end

  // Next-state logic; a new request beats the start-clear of its pending bit.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    first_d   = 1'b0;
    pending_d = (pending_q & ~start_o) | req_i;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StRun;
        first_d = 1'b1;
      end
      StRun: begin
        if (!granted_busy) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = (g_idx == PtrW'(N_CLIENTS - 1)) ? '0 : g_idx + PtrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; grant_q is already zero outside LAUNCH/RUN.
  always_comb begin
    start_o = (state_q == StLaunch) ? grant_q : '0;
    grant_o = grant_q;
    busy    = (state_q != StIdle);
    err_o   = release_run && first_q;
  end

  // Operand mux and the shared adder; only the granted slice can reach the sum.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      if (grant_q[i]) begin
        a_sel = sum_in_a_i[i*WIDTH +: WIDTH];
        b_sel = sum_in_b_i[i*WIDTH +: WIDTH];
      end
    end
    sum_out = busy ? (a_sel + b_sel) : '0;
  end

`ifdef SUM_ARB_STATS_EN
  logic [N_CLIENTS-1:0][CountWidth-1:0] cnt_q, cnt_d;

  // Saturating per-client release counters, error releases included.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      if (release_run && grant_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CountWidth'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign txn_count = cnt_q;
`endif

endmodule
